// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT signed products per block, holds result for handshake.
// Optional macro ACC_SAT_EN: saturating accumulation instead of two's-complement wrap.
module product_accumulator #(
  parameter int BIT_LEN = 4,
  parameter int ACC_LEN = 16,
  parameter int COUNT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*BIT_LEN-1:0] prod,
  input  logic                 prod_r,
  input  logic                 clear,
  output logic [ACC_LEN-1:0]   sum,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic                 ovf,
  output logic                 overrun
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  localparam logic [CW-1:0] FULL = CW'(COUNT);

  typedef enum logic {
    S_ACC,
    S_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_LEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*BIT_LEN-1:0] pend_q, pend_d;
  logic                 pend_v_q, pend_v_d;
  logic                 prev_q, prev_d;
  logic                 ovf_q, ovf_d;
  logic                 ovr_q, ovr_d;

  logic                 det;
  logic [ACC_LEN-1:0]   prod_x;
  logic [ACC_LEN-1:0]   pend_x;
  logic [ACC_LEN-1:0]   hs_base;
  logic [ACC_LEN-1:0]   hs_term;
  logic [ACC_LEN:0]     add_a;
  logic [ACC_LEN:0]     add_h;

  // Returns {overflow, result}; result wraps or clamps by build.
  function automatic logic [ACC_LEN:0] add_f(
    input logic [ACC_LEN-1:0] a,
    input logic [ACC_LEN-1:0] b
  );
    logic [ACC_LEN-1:0] s;
    logic               o;
    s = a + b;
    o = (a[ACC_LEN-1] == b[ACC_LEN-1]) &&
        (s[ACC_LEN-1] != a[ACC_LEN-1]);
`ifdef ACC_SAT_EN
    if (o) begin
      s = a[ACC_LEN-1] ? {1'b1, {(ACC_LEN-1){1'b0}}}
                       : {1'b0, {(ACC_LEN-1){1'b1}}};
    end
`endif
    return {o, s};
  endfunction

  assign det     = prod_r & ~prev_q;
  assign prod_x  = ACC_LEN'($signed(prod));
  assign pend_x  = ACC_LEN'($signed(pend_q));
  assign hs_base = pend_v_q ? pend_x : '0;
  assign hs_term = det ? prod_x : '0;
  assign add_a   = add_f(acc_q, prod_x);
  assign add_h   = add_f(hs_base, hs_term);

  // Next-state: accumulate in ACC, park one product in HOLD, restart on handshake.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    prev_d   = prod_r;
    ovf_d    = ovf_q;
    ovr_d    = ovr_q;
    unique case (state_q)
      S_ACC: begin
        if (det) begin
          acc_d = add_a[ACC_LEN-1:0];
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q | add_a[ACC_LEN];
          if (cnt_q == LAST) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (sum_ready) begin
          acc_d    = add_h[ACC_LEN-1:0];
          cnt_d    = CW'(pend_v_q) + CW'(det);
          pend_v_d = 1'b0;
          ovf_d    = add_h[ACC_LEN];
          state_d  = (cnt_d == FULL) ? S_HOLD : S_ACC;
        end else if (det) begin
          if (pend_v_q) begin
            ovr_d = 1'b1;
          end else begin
            pend_d   = prod;
            pend_v_d = 1'b1;
          end
        end
      end
    endcase
    if (clear) begin
      state_d  = S_ACC;
      acc_d    = '0;
      cnt_d    = '0;
      pend_v_d = 1'b0;
      ovf_d    = 1'b0;
      ovr_d    = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      prev_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      prev_q   <= prev_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sum       = acc_q;
  assign sum_valid = (state_q == S_HOLD);
  assign ovf       = ovf_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed scenarios plus random traffic vs a queue-based model.
// Second instance uses ACC_LEN=8 to exercise overflow (wrap or ACC_SAT_EN clamp).
module tb_product_accumulator;

  localparam int BL = 4;
  localparam int CNT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  prod = '0;
  logic        prod_r = 1'b0;
  logic        clear = 1'b0;
  logic        sum_ready = 1'b0;
  logic [15:0] sum;
  logic        sum_valid, ovf, overrun;
  logic [7:0]  sum8;
  logic        sum_valid8, ovf8, overrun8;

  int checks = 0;
  int errors = 0;

  // Model: terms of the current block, one-entry pending queue, flags.
  int m_blk[$];
  int m_pend[$];
  bit m_prev, m_hold, m_ovr;

  product_accumulator #(.BIT_LEN(BL), .ACC_LEN(16), .COUNT(CNT)) dut (
    .clk(clk), .rst(rst), .prod(prod), .prod_r(prod_r), .clear(clear),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .ovf(ovf), .overrun(overrun));

  product_accumulator #(.BIT_LEN(BL), .ACC_LEN(8), .COUNT(CNT)) dut8 (
    .clk(clk), .rst(rst), .prod(prod), .prod_r(prod_r), .clear(clear),
    .sum(sum8), .sum_valid(sum_valid8), .sum_ready(sum_ready),
    .ovf(ovf8), .overrun(overrun8));

  always #5 clk = ~clk;

  // Sequential sum of the block's terms in an L-bit signed accumulator.
  function automatic int fold(input int L, output bit o);
    int s;
    int t;
    int lim;
    s = 0;
    o = 1'b0;
    lim = 1 << (L - 1);
    foreach (m_blk[i]) begin
      t = s + m_blk[i];
      if (t >= lim || t < -lim) begin
        o = 1'b1;
`ifdef ACC_SAT_EN
        t = (t >= lim) ? lim - 1 : -lim;
`else
        t = t & ((1 << L) - 1);
        if (t >= lim) t = t - (1 << L);
`endif
      end
      s = t;
    end
    return s;
  endfunction

  task automatic model_step();
    bit det;
    int p;
    det = prod_r && !m_prev;
    p = int'($signed(prod));
    m_prev = prod_r;
    if (rst) begin
      m_prev = 0; m_hold = 0; m_ovr = 0;
      m_blk.delete(); m_pend.delete();
    end else if (clear) begin
      m_hold = 0; m_ovr = 0;
      m_blk.delete(); m_pend.delete();
    end else if (!m_hold) begin
      if (det) begin
        m_blk.push_back(p);
        if (m_blk.size() == CNT) m_hold = 1;
      end
    end else if (sum_ready) begin
      m_blk = m_pend;
      if (det) m_blk.push_back(p);
      m_pend.delete();
      m_hold = (m_blk.size() == CNT);
    end else if (det) begin
      if (m_pend.size() != 0) m_ovr = 1;
      else m_pend.push_back(p);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input int p);
    prod = 8'(p);
    prod_r = 1'b1;
    tick();
    prod_r = 1'b0;
    tick();
  endtask

  task automatic handshake();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (sum !== 16'd0) begin
      errors++; $display("FAIL reset_sum got %0d want 0", sum);
    end
    checks++;
    if ({sum_valid, ovf, overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {sum_valid, ovf, overrun});
    end
  endtask

  task automatic test_basic();
    pulse(6); pulse(-12); pulse(49);
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid got %b want 0", sum_valid);
    end
    prod = 8'(-8);
    prod_r = 1'b1;
    tick();
    checks++;
    if (sum_valid !== 1'b1 || $signed(sum) !== 16'sd35 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum got v=%b s=%0d o=%b want v=1 s=35 o=0",
               sum_valid, $signed(sum), ovf);
    end
    prod_r = 1'b0;
    tick();
    checks++;
    if (sum_valid !== 1'b1 || $signed(sum) !== 16'sd35) begin
      errors++; $display("FAIL basic_hold got v=%b s=%0d want v=1 s=35", sum_valid, $signed(sum));
    end
    handshake();
    checks++;
    if (sum_valid !== 1'b0 || sum !== 16'd0) begin
      errors++; $display("FAIL basic_hs got v=%b s=%0d want v=0 s=0", sum_valid, sum);
    end
  endtask

  task automatic test_held_level();
    prod = 8'd5;
    prod_r = 1'b1;
    repeat (10) tick();
    prod_r = 1'b0;
    tick();
    pulse(1); pulse(1); pulse(1);
    checks++;
    if (sum_valid !== 1'b1 || $signed(sum) !== 16'sd8) begin
      errors++; $display("FAIL held_sum got v=%b s=%0d want v=1 s=8", sum_valid, $signed(sum));
    end
    handshake();
  endtask

  task automatic test_overrun();
    pulse(1); pulse(1); pulse(1); pulse(1);
    pulse(7);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_early got %b want 0", overrun);
    end
    pulse(3);
    checks++;
    if (overrun !== 1'b1 || sum_valid !== 1'b1 || $signed(sum) !== 16'sd4) begin
      errors++;
      $display("FAIL ovr_set got ovr=%b v=%b s=%0d want 1 1 4", overrun, sum_valid, $signed(sum));
    end
    handshake();
    checks++;
    if ($signed(sum) !== 16'sd7 || sum_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_hs got s=%0d v=%b ovr=%b want 7 0 1", $signed(sum), sum_valid, overrun);
    end
    pulse(1); pulse(1); pulse(1);
    checks++;
    if (sum_valid !== 1'b1 || $signed(sum) !== 16'sd10) begin
      errors++; $display("FAIL ovr_next got v=%b s=%0d want v=1 s=10", sum_valid, $signed(sum));
    end
    handshake();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_overflow8();
    pulse(49); pulse(49); pulse(49); pulse(49);
    checks++;
`ifdef ACC_SAT_EN
    if ($signed(sum8) !== 8'sd127 || ovf8 !== 1'b1 || sum_valid8 !== 1'b1) begin
      errors++; $display("FAIL ovf8 got s=%0d o=%b want s=127 o=1", $signed(sum8), ovf8);
    end
`else
    if ($signed(sum8) !== -8'sd60 || ovf8 !== 1'b1 || sum_valid8 !== 1'b1) begin
      errors++; $display("FAIL ovf8 got s=%0d o=%b want s=-60 o=1", $signed(sum8), ovf8);
    end
`endif
    checks++;
    if ($signed(sum) !== 16'sd196 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf16 got s=%0d o=%b want s=196 o=0", $signed(sum), ovf);
    end
    handshake();
    checks++;
    if (ovf8 !== 1'b0) begin
      errors++; $display("FAIL ovf8_hs got %b want 0", ovf8);
    end
  endtask

  task automatic test_reset_mid();
    pulse(10); pulse(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (sum !== 16'd0 || {sum_valid, ovf, overrun} !== 3'b000) begin
      errors++; $display("FAIL rstmid got s=%0d f=%b want 0 000", sum, {sum_valid, ovf, overrun});
    end
    pulse(2); pulse(2); pulse(2); pulse(2);
    checks++;
    if (sum_valid !== 1'b1 || $signed(sum) !== 16'sd8) begin
      errors++; $display("FAIL rstmid_sum got v=%b s=%0d want v=1 s=8", sum_valid, $signed(sum));
    end
    handshake();
  endtask

  task automatic test_hs_collide();
    pulse(1); pulse(2); pulse(3); pulse(4);
    pulse(4);
    prod = 8'd9;
    prod_r = 1'b1;
    sum_ready = 1'b1;
    tick();
    prod_r = 1'b0;
    sum_ready = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || $signed(sum) !== 16'sd13 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL collide got v=%b s=%0d ovr=%b want 0 13 0", sum_valid, $signed(sum), overrun);
    end
    tick();
    pulse(1); pulse(1);
    checks++;
    if (sum_valid !== 1'b1 || $signed(sum) !== 16'sd15) begin
      errors++; $display("FAIL collide_cnt got v=%b s=%0d want v=1 s=15", sum_valid, $signed(sum));
    end
    handshake();
  endtask

  task automatic test_random();
    bit o16, o8;
    int e16, e8;
    for (int i = 0; i < 600; i++) begin
      prod = 8'($urandom_range(0, 255));
      prod_r = ($urandom_range(0, 1) == 1);
      sum_ready = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 59) == 0);
      tick();
      e16 = fold(16, o16);
      e8 = fold(8, o8);
      checks++;
      if (int'($signed(sum)) != e16 || ovf !== o16) begin
        errors++; $display("FAIL rnd_sum16 cyc %0d got %0d/%b want %0d/%b",
                           i, $signed(sum), ovf, e16, o16);
      end
      checks++;
      if (sum_valid !== m_hold || overrun !== m_ovr) begin
        errors++; $display("FAIL rnd_flags cyc %0d got v=%b ovr=%b want v=%b ovr=%b",
                           i, sum_valid, overrun, m_hold, m_ovr);
      end
      checks++;
      if (int'($signed(sum8)) != e8 || ovf8 !== o8) begin
        errors++; $display("FAIL rnd_sum8 cyc %0d got %0d/%b want %0d/%b",
                           i, $signed(sum8), ovf8, e8, o8);
      end
    end
    prod_r = 1'b0;
    sum_ready = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_level();
    test_overrun();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_overflow8();
    test_reset_mid();
    test_hs_collide();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter BIT_LEN, default 4, operand width of the upstream Booth multiplier; the product is 2*BIT_LEN bits.
REQ-002 SHALL have parameter ACC_LEN, default 16, accumulator/sum width; legal range ACC_LEN >= 2*BIT_LEN.
REQ-003 SHALL have parameter COUNT, default 8, products per block; legal range COUNT >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port prod  input  2*BIT_LEN  signed product from multiplier out.
REQ-007 SHALL have port prod_r  input  1  multiplier result-ready level (out_r); may stay high for many cycles.
REQ-008 SHALL have port clear  input  1  synchronous block abort.
REQ-009 SHALL have port sum  output  ACC_LEN  signed block sum.
REQ-010 SHALL have port sum_valid  output  1  sum is valid.
REQ-011 SHALL have port sum_ready  input  1  consumer accepts sum.
REQ-012 SHALL have port ovf  output  1  current block overflowed; sticky until block handshake.
REQ-013 SHALL have port overrun  output  1  product lost; sticky until rst or clear.

Function
REQ-014 SHALL detect a new product when prod_r=1 and the registered previous prod_r=0 (one capture per rising level); the previous-prod_r register resets to 0.
REQ-015 SHALL sign-extend prod to ACC_LEN before addition.
REQ-016 SHALL implement two states: ACC (accumulating, cnt < COUNT) and HOLD (sum_valid=1, awaiting handshake).
REQ-017 In ACC, on detection: acc <= acc + prod, cnt <= cnt + 1; when cnt was COUNT-1, go to HOLD and assert sum_valid on the same edge (one-cycle latency from detection cycle).
REQ-018 sum SHALL equal acc and be stable while sum_valid=1.
REQ-019 Handshake SHALL occur on an edge with sum_valid=1 and sum_ready=1; then sum_valid <= 0, ovf <= 0, state <= ACC.
REQ-020 In HOLD, a detected product SHALL be stored in a one-entry pending register (pend, pend_v).
REQ-021 In HOLD with pend_v=1, a further detection SHALL discard that product and set overrun.
REQ-022 At handshake, new acc SHALL be (pend_v ? pend : 0) + (detection ? prod : 0), cnt the number of terms (0..2), pend_v <= 0; a detection on the handshake edge is never lost.
REQ-023 ovf SHALL set when any addition in the current block exceeds the signed ACC_LEN range.
REQ-024 clear SHALL zero acc, cnt, pend_v, sum_valid, ovf, overrun and enter ACC on the next edge; rst has priority over clear.

Reset
REQ-025 On rst=1 at a clock edge: state=ACC, acc=0, cnt=0, pend_v=0, previous prod_r=0, sum=0, sum_valid=0, ovf=0, overrun=0.
REQ-026 rst mid-block SHALL discard partial sums and pending products with no output.

Configuration
REQ-027 Macro ACC_SAT_EN: when defined, an overflowing addition SHALL clamp acc to 2^(ACC_LEN-1)-1 or -2^(ACC_LEN-1) and remain clamped by subsequent saturating additions.
REQ-028 Without ACC_SAT_EN, addition SHALL wrap in two's complement; ovf behaves identically in both builds.

Verification (BIT_LEN=4, COUNT=4, ACC_LEN=16 unless stated)
REQ-029 Products 6, -12, 49, -8, each a fresh prod_r rise -> sum_valid one cycle after 4th detection, sum=35, ovf=0.
REQ-030 prod_r held high 10 cycles with prod=5, then three more rises of 1 -> sum=8 (held level counted once).
REQ-031 sum_ready=0 in HOLD, products 7 then 3 arrive -> overrun=1, after handshake acc=7, cnt=1; three further 1s -> sum=10.
REQ-032 ACC_LEN=8, four products of 49 -> with ACC_SAT_EN sum=127, ovf=1; without, sum=-60, ovf=1.
REQ-033 rst for one cycle after two products of 10 -> all outputs 0; next four products of 2 -> sum=8.
REQ-034 Handshake edge coincides with detection of 9, pend_v=1 holding 4 -> acc=13, cnt=2, no overrun.
